// File: rtl/vx_fifo_share_pkg.sv
// Shared types and helpers for the shared-FIFO arbiter.
// Build option: define VX_FIFO_SHARE_QUOTA_EN to enable quota gating.
package vx_fifo_share_pkg;

`ifdef VX_FIFO_SHARE_QUOTA_EN
    localparam bit QUOTA_EN = 1'b1;
`else
    localparam bit QUOTA_EN = 1'b0;
`endif

    // Default entry shape; the top re-declares it at its own widths.
    localparam int SHARE_TAGW  = 2;
    localparam int SHARE_DATAW = 32;

    typedef struct packed {
        logic [SHARE_TAGW-1:0]  tag;
        logic [SHARE_DATAW-1:0] data;
    } share_entry_t;

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counters only need to reach QUOTA when the quota gate is active.
    function automatic int cnt_width(input int quota, input int depth);
        return $clog2((QUOTA_EN ? quota : depth) + 1);
    endfunction

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/VX_fifo_queue.sv
// Circular FIFO; head visible the cycle after push in both output modes.
// Ports: clk, reset, push/data_in, pop, data_out, empty, full, size.
module VX_fifo_queue #(
    parameter int DATAW   = 32,
    parameter int DEPTH   = 16,
    parameter int OUT_REG = 0,
    parameter int LUTRAM  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATAW-1:0]           data_in,
    output logic [DATAW-1:0]           data_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] size
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH+1);

    logic [DATAW-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [SW-1:0]    count;

    // Storage style is left to the tool; both modes behave the same.
    logic unused_lutram;
    assign unused_lutram = (LUTRAM != 0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + SW'(1);
            else if (pop && !push)
                count <= count - SW'(1);
        end
    end

    assign empty = (count == '0);
    assign full  = (count == SW'(DEPTH));
    assign size  = count;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATAW-1:0] head_r;
            // Load the head register with whatever becomes the new head.
            always_ff @(posedge clk) begin
                if (push && (empty || (pop && count == SW'(1))))
                    head_r <= data_in;
                else if (pop && count > SW'(1))
                    head_r <= mem[rd_ptr + AW'(1)];
            end
            assign data_out = head_r;
        end else begin : g_out_comb
            assign data_out = mem[rd_ptr];
        end
    endgenerate

endmodule

// File: rtl/VX_rr_grant.sv
// Round-robin priority select: first eligible index at or after ptr.
// Ports: eligible mask, ptr in; one-hot grant, grant_idx, grant_valid out.
module VX_rr_grant #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    always_comb begin
        int j;
        j = 0;
        grant = '0;
        grant_idx = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            // ptr is always < N, so one subtract wraps it.
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!grant_valid && eligible[j]) begin
                grant[j] = 1'b1;
                grant_idx = W'(j);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_fifo_share_arb.sv
// N producers share one FIFO via round-robin admission; entries carry tags.
// Ports: in_valid/in_data/in_ready per requester; out_valid/out_data/out_tag/
// out_ready consumer; size and per-requester req_count occupancy.
// Build option: VX_FIFO_SHARE_QUOTA_EN caps each requester at QUOTA entries.
module vx_fifo_share_arb
    import vx_fifo_share_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter int DEPTH    = 16,
    parameter int QUOTA    = 8,
    parameter int OUT_REG  = 0,
    parameter int LUTRAM   = 0
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_REQS-1:0]                        in_valid,
    input  logic [NUM_REQS*DATAW-1:0]                  in_data,
    output logic [NUM_REQS-1:0]                        in_ready,
    output logic                                       out_valid,
    output logic [DATAW-1:0]                           out_data,
    output logic [tag_width(NUM_REQS)-1:0]             out_tag,
    input  logic                                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0]                 size,
    output logic [NUM_REQS*cnt_width(QUOTA,DEPTH)-1:0] req_count
);

    localparam int TAGW    = tag_width(NUM_REQS);
    localparam int CNTW    = cnt_width(QUOTA, DEPTH);
    localparam int CNT_MAX = QUOTA_EN ? QUOTA : DEPTH;

    typedef struct packed {
        logic [TAGW-1:0]  tag;
        logic [DATAW-1:0] data;
    } entry_t;

    logic [CNTW-1:0]     req_cnt [NUM_REQS];
    logic [TAGW-1:0]     rr_ptr;
    logic [NUM_REQS-1:0] eligible;
    logic [NUM_REQS-1:0] grant;
    logic [TAGW-1:0]     grant_idx;
    logic                grant_valid;
    logic                push;
    logic                pop;
    logic                empty;
    logic                full;
    logic                can_push;
    entry_t              push_entry;
    entry_t              head_entry;

    assign pop      = out_valid && out_ready;
    assign can_push = !full || pop;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
`ifdef VX_FIFO_SHARE_QUOTA_EN
            eligible[i] = in_valid[i] && can_push
                       && (req_cnt[i] < CNTW'(QUOTA));
`else
            eligible[i] = in_valid[i] && can_push;
`endif
        end
    end

    VX_rr_grant #(
        .N (NUM_REQS),
        .W (TAGW)
    ) rr_grant (
        .eligible    (eligible),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign in_ready = reset ? '0 : grant;
    assign push     = grant_valid && !reset;

    assign push_entry.tag  = grant_idx;
    assign push_entry.data = in_data[grant_idx*DATAW +: DATAW];

    VX_fifo_queue #(
        .DATAW   (TAGW + DATAW),
        .DEPTH   (DEPTH),
        .OUT_REG (OUT_REG),
        .LUTRAM  (LUTRAM)
    ) queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (push_entry),
        .data_out (head_entry),
        .empty    (empty),
        .full     (full),
        .size     (size)
    );

    assign out_valid = !empty;
    assign out_data  = head_entry.data;
    assign out_tag   = head_entry.tag;

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (push)
            rr_ptr <= TAGW'(rr_next(int'(grant_idx), NUM_REQS));
    end

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_cnt
        logic inc;
        logic dec;
        assign inc = push && (grant_idx == TAGW'(i));
        assign dec = pop && (out_tag == TAGW'(i));

        always_ff @(posedge clk) begin
            if (reset)
                req_cnt[i] <= '0;
            else if (inc && !dec)
                req_cnt[i] <= req_cnt[i] + CNTW'(1);
            else if (dec && !inc)
                req_cnt[i] <= req_cnt[i] - CNTW'(1);
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                if (inc && !dec)
                    assert (req_cnt[i] != CNTW'(CNT_MAX));
                if (dec && !inc)
                    assert (req_cnt[i] != '0);
            end
        end

        assign req_count[i*CNTW +: CNTW] = req_cnt[i];
    end

endmodule

// File: doc/vx_fifo_share_arb.md
# vx_fifo_share_arb

Shares one FIFO queue among `NUM_REQS` producers. Each cycle a round-robin arbiter admits at most one requester's data into the queue and tags the entry with the requester index. The consumer drains entries in arrival order through a single valid/ready port. An optional per-requester occupancy quota stops one producer from monopolising the queue. The block sits between per-lane producers (e.g. ray-request generators) and a shared downstream unit.

## Interface
Parameters:
- `NUM_REQS`, 4: number of requesters; ≥1.
- `DATAW`, 32: payload width.
- `DEPTH`, 16: queue entries; power of 2, ≥2.
- `QUOTA`, 8: maximum entries one requester may hold; 1 ≤ QUOTA ≤ DEPTH.
- `OUT_REG`, 0: passed to the internal queue; registered output when nonzero.
- `LUTRAM`, 0: passed to the internal queue.
- `TAGW` (localparam): `CLOG2(NUM_REQS)`, minimum 1.
- `CNTW` (localparam): `CLOG2(QUOTA+1)`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset; synchronous, active-high.
- `in_valid`, in, NUM_REQS: per-requester request.
- `in_data`, in, NUM_REQS×DATAW: per-requester payload.
- `in_ready`, out, NUM_REQS: one-hot or zero; high for the requester admitted this cycle.
- `out_valid`, out, 1: queue non-empty.
- `out_data`, out, DATAW: head payload.
- `out_tag`, out, TAGW: requester index of the head entry.
- `out_ready`, in, 1: consumer accepts the head.
- `size`, out, `CLOG2(DEPTH+1)`: queue occupancy.
- `req_count`, out, NUM_REQS×CNTW: per-requester occupancy.

## Operation
Eligibility and grant:
- Requester i is eligible when `in_valid[i]`, the queue is not full (or a pop occurs this cycle), and `req_count[i] < QUOTA` (quota check only with the macro).
- The grant is round-robin among eligible requesters, starting at pointer `rr_ptr`. It is combinational; `in_ready` equals the grant.
- `push` = any grant. The queue stores {tag, data}.
- `rr_ptr` advances to (granted index + 1) mod NUM_REQS only on a push. Otherwise it holds.

Pop:
- `pop` = `out_valid && out_ready`.

Per-requester counters:
- On push from i, `req_count[i]` increments.
- On pop with `out_tag == j`, `req_count[j]` decrements.
- If i == j in the same cycle, the count is unchanged.
- Counters never wrap. Overflow or underflow is a runtime assertion.

Boundary conditions:
- Full and pop in the same cycle: push is allowed. `size` is unchanged.
- Empty: `out_valid` is 0, and `out_ready` is ignored.
- The `rr_ptr` wrap from NUM_REQS-1 goes to 0.
- Reset mid-operation: all contents are discarded; state and outputs return to their reset values.

## Timing
- Reset values: `in_ready` = 0 while `reset` is high; `out_valid` = 0; `size` = 0; all `req_count` = 0; `rr_ptr` = 0. `out_data` and `out_tag` are don't-care while `out_valid` = 0.
- Latency: an entry pushed at cycle t appears at the output with `out_valid` = 1 in cycle t+1, for both `OUT_REG` settings.
- Throughput: one push and one pop per cycle, sustained.
- `in_ready[i]` depends combinationally on `in_valid` and `out_ready`.
- No combinational path exists from `in_valid` to `out_valid`.

## Configuration
- `VX_FIFO_SHARE_QUOTA_EN` defined: quota gating is active, and `req_count` tracks occupancy as specified.
- Not defined: no quota gating; requesters are limited only by the queue being full. `req_count` is still tracked, and its width grows to `CLOG2(DEPTH+1)`.

## Structure
- Package `vx_fifo_share_pkg`:
  - an entry struct type {tag, data}, parameterised by width localparams;
  - helper function `rr_next(ptr, n)`.
- One sub-module, `VX_rr_grant`: round-robin priority select. It takes the eligible mask and pointer, and outputs a one-hot grant and its index.
- Storage: one `VX_fifo_queue` instance with DATAW = TAGW + DATAW.

## Test plan
- Reset, then all `in_valid` = 4'b1111 with `out_ready` = 1 → grants 0, 1, 2, 3, 0… on consecutive cycles. `out_tag` follows the same sequence one cycle later.
- Single requester 2 pushes 0xA5 at cycle t, consumer ready → `out_valid` = 1 and `out_data` = 0xA5 with `out_tag` = 2 at t+1. `size` returns to 0 at t+2.
- With the macro defined and QUOTA = 8, requester 0 streams with `out_ready` = 0 → exactly 8 pushes. Then `in_ready[0]` = 0 while requester 1 is still admitted, up to DEPTH = 16.
- Queue full and `out_ready` = 1 with requester 3 valid → requester 3 is admitted, `size` stays 16, and `req_count` updates for both the pushed and popped tags.
- Reset asserted with `size` = 5 → next cycle `out_valid` = 0, `size` = 0, all counts 0, and the first grant goes to requester 0.
- Without the macro and QUOTA = 1, one requester fills all 16 entries → `in_ready` drops only when the queue is full.
